// File: rtl/axi_lite_pkg.sv
// Shared types and register-map constants for the AXI4-Lite FIFO slave.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    RespOkay   = 2'b00,
    RespExOkay = 2'b01,
    RespSlvErr = 2'b10,
    RespDecErr = 2'b11
  } resp_t;

  // Register offsets, decoded from ADDR[3:2]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int unsigned STATUS_EMPTY   = 0;
  localparam int unsigned STATUS_FULL    = 1;
  localparam int unsigned STATUS_OVF     = 2;
  localparam int unsigned STATUS_CNT_LSB = 8;
  localparam int unsigned STATUS_CNT_W   = 8;

  localparam int unsigned CTRL_FLUSH   = 0;
  localparam int unsigned CTRL_CLR_OVF = 1;

  typedef enum logic {WIdle, WResp} w_state_e;
  typedef enum logic {RIdle, RData} r_state_e;

endpackage

// File: rtl/axi_lite_fifo_slave_if.sv
// AXI4-Lite five-channel bundle with master and slave views.
interface axi_lite_fifo_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head output and synchronous flush.
module sync_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned PtrW      = $clog2(DEPTH),
  localparam int unsigned CntW      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty,
  output logic [CntW-1:0]       count
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q;
  logic                  do_push, do_pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign rdata = mem_q[rd_ptr_q];

  // A pop frees a slot on the same edge, so a push into a full FIFO is legal then
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end
endmodule

// File: rtl/axi_lite_fifo_slave.sv
// AXI4-Lite slave exposing a memory-mapped FIFO (DATA/STATUS/CTRL/reserved).
module axi_lite_fifo_slave #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 16
) (
  input logic                  aclk,
  input logic                  aresetn,
  axi_lite_fifo_slave_if.slave axi
);
  import axi_lite_pkg::*;

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned CntW  = $clog2(DEPTH) + 1;

  w_state_e              w_state_q, w_state_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  resp_t                 bresp_q, bresp_d, wr_resp;
  logic [1:0]            waddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [StrbW-1:0]      wstrb_q;
  logic                  ovf_q, ovf_d;
  logic                  aw_fire, w_fire, w_commit;

  r_state_e              r_state_q, r_state_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word, status_word;
  resp_t                 rresp_q, rresp_d, rd_resp;
  logic                  ar_fire, pop_fire;

  logic                  fifo_push, fifo_flush, fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic [CntW-1:0]       fifo_count;
  logic                  wr_data_sel, wr_ctrl_sel, wr_has_strb, push_blocked, ovf_set, ovf_clr;

  logic unused_addr;
  assign unused_addr = ^{axi.awaddr[ADDR_WIDTH-1:4], axi.awaddr[1:0],
                         axi.araddr[ADDR_WIDTH-1:4], axi.araddr[1:0]};

  sync_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (fifo_push),
    .pop   (pop_fire),
    .flush (fifo_flush),
    .wdata (wdata_q),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign aw_fire  = axi.awvalid && awready_q;
  assign w_fire   = axi.wvalid && wready_q;
  assign ar_fire  = axi.arvalid && arready_q;
  assign pop_fire = ar_fire && (axi.araddr[3:2] == REG_DATA) && !fifo_empty;

  // Write-side decode of the latched AW/W beat
  assign wr_data_sel  = (waddr_q == REG_DATA);
  assign wr_ctrl_sel  = (waddr_q == REG_CTRL);
  assign wr_has_strb  = |wstrb_q;
  assign push_blocked = fifo_full && !pop_fire;
  assign wr_resp      = (wr_data_sel && wr_has_strb && push_blocked) ? RespSlvErr : RespOkay;
  assign fifo_push    = w_commit && wr_data_sel && wr_has_strb && !push_blocked;
  assign ovf_set      = w_commit && wr_data_sel && wr_has_strb && push_blocked;
  assign fifo_flush   = w_commit && wr_ctrl_sel && wstrb_q[0] && wdata_q[CTRL_FLUSH];
  assign ovf_clr      = w_commit && wr_ctrl_sel && wstrb_q[0] && wdata_q[CTRL_CLR_OVF];

  always_comb begin
    w_state_d = w_state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    w_commit  = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (aw_fire) aw_done_d = 1'b1;
        if (w_fire)  w_done_d  = 1'b1;
        if (aw_done_q && w_done_q) begin
          w_commit  = 1'b1;
          bvalid_d  = 1'b1;
          bresp_d   = wr_resp;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = WResp;
        end
      end
      WResp: begin
        if (axi.bready) begin
          bvalid_d  = 1'b0;
          w_state_d = WIdle;
        end
      end
      default: w_state_d = WIdle;
    endcase
    awready_d = (w_state_d == WIdle) && !aw_done_d;
    wready_d  = (w_state_d == WIdle) && !w_done_d;
    ovf_d     = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_comb begin
    status_word = '0;
    status_word[STATUS_EMPTY] = fifo_empty;
    status_word[STATUS_FULL]  = fifo_full;
    status_word[STATUS_OVF]   = ovf_q;
    status_word[STATUS_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(fifo_count);
  end

  always_comb begin
    rd_word = '0;
    rd_resp = RespOkay;
    unique case (axi.araddr[3:2])
      REG_DATA: begin
        if (fifo_empty) rd_resp = RespSlvErr;
        else            rd_word = fifo_rdata;
      end
      REG_STATUS:         rd_word = status_word;
      REG_CTRL, REG_RSVD: rd_word = '0;
      default:            rd_word = '0;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      RIdle: begin
        if (ar_fire) begin
          rvalid_d  = 1'b1;
          rdata_d   = rd_word;
          rresp_d   = rd_resp;
          r_state_d = RData;
        end
      end
      RData: begin
        if (axi.rready) begin
          rvalid_d  = 1'b0;
          r_state_d = RIdle;
        end
      end
      default: r_state_d = RIdle;
    endcase
    arready_d = (r_state_d == RIdle);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= WIdle;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      ovf_q     <= 1'b0;
      r_state_q <= RIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
    end else begin
      w_state_q <= w_state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      ovf_q     <= ovf_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      if (aw_fire) waddr_q <= axi.awaddr[3:2];
      if (w_fire) begin
        wdata_q <= axi.wdata;
        wstrb_q <= axi.wstrb;
      end
    end
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bresp   = bresp_q;
  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid_q;
  assign axi.rdata   = rdata_q;
  assign axi.rresp   = rresp_q;
endmodule

// File: doc/axi_lite_fifo_slave.md
Name: axi_lite_fifo_slave

Overview:
AXI4-Lite slave peripheral that sits directly downstream of the team's AXI4-Lite master and terminates its five channels. It exposes a memory-mapped 32-bit FIFO through four registers: DATA, STATUS, CTRL and a reserved slot. Writes to DATA push into the FIFO and reads from DATA pop from it, so the master's transfer/write/addr/wdata sequences act as a loopback queue with status and error reporting.

Parameters:
DATA_WIDTH, 32, AXI data bus width and FIFO word width.
ADDR_WIDTH, 32, AXI address width; only ADDR[3:2] are decoded.
DEPTH, 16, FIFO entries; must be a power of 2 and at least 2.

Ports:
ACLK  in  1  system clock; all state updates on rising edge.
ARESETn  in  1  asynchronous active-low reset.
AWADDR  in  ADDR_WIDTH  write address.
AWVALID / AWREADY  in / out  1  write-address handshake.
WDATA  in  DATA_WIDTH  write data.
WSTRB  in  DATA_WIDTH/8  byte strobes.
WVALID / WREADY  in / out  1  write-data handshake.
BRESP  out  2  write response: OKAY=2'b00, SLVERR=2'b10.
BVALID / BREADY  out / in  1  write-response handshake.
ARADDR  in  ADDR_WIDTH  read address.
ARVALID / ARREADY  in / out  1  read-address handshake.
RDATA  out  DATA_WIDTH  read data.
RRESP  out  2  read response.
RVALID / RREADY  out / in  1  read-data handshake.

Behaviour:
- Reset (async assert, sync release) sets every output and all state to 0: AWREADY, WREADY, BVALID, ARREADY, RVALID, BRESP, RRESP, RDATA, FIFO count, pointers, overflow flag.
- Register map (ADDR[3:2]):
  - 0x0 DATA: write pushes; read pops.
  - 0x4 STATUS (read-only): bit0 empty, bit1 full, bit2 overflow (sticky), bits[15:8] count. Writes are ignored and return OKAY.
  - 0x8 CTRL (write-only; reads return 0): bit0 flush, bit1 clear overflow. Both bits are self-clearing pulses.
  - 0xC reserved: reads return 0, writes are ignored; both return OKAY.
- Write path FSM, states W_IDLE / W_RESP:
  - In W_IDLE, AWREADY=1 until AW is captured and WREADY=1 until W is captured. AW and W may arrive in either order or in the same cycle; each is latched independently.
  - The cycle after both are captured, the write commits on that edge, BVALID rises and the FSM enters W_RESP.
  - Minimum latency: AW+W handshake at edge N, BVALID=1 after edge N+1.
  - W_RESP holds BVALID and BRESP stable until BREADY, then returns to W_IDLE with AWREADY=WREADY=1 on the next cycle.
- Read path FSM, states R_IDLE / R_DATA:
  - ARREADY=1 in R_IDLE.
  - On the AR handshake edge, RDATA and RRESP are registered, any pop commits, RVALID rises and the FSM enters R_DATA. Latency is 1 cycle.
  - RDATA and RRESP hold until RREADY, then the FSM returns to R_IDLE.
- DATA push:
  - WSTRB==0: no-op, OKAY.
  - Otherwise the full word is pushed (partial strobes still push the full WDATA).
  - FIFO full: no push, overflow flag set, BRESP=SLVERR.
- DATA pop when empty: RDATA=0, RRESP=SLVERR, pointers unchanged.
- Simultaneous push commit and pop commit on the same edge: both take effect and count is unchanged. When full, a push on the same edge as a pop succeeds. When empty, a pop on the same edge as a push returns SLVERR (the pop sees pre-edge state).
- CTRL flush on the same edge as a pop: the pop uses pre-flush data and the FIFO is empty afterwards.
- STATUS reads sample pre-edge state.
- Pointers wrap modulo DEPTH. Count width is $clog2(DEPTH)+1.
- Write and read paths are independent; they may be busy concurrently.
- ARESETn asserted mid-transaction: the transaction is abandoned, FIFO contents are lost and all VALIDs drop immediately.

Decomposition:
- Package axi_lite_pkg:
  - resp_t enum (OKAY, EXOKAY, SLVERR, DECERR).
  - Register offset localparams (REG_DATA=2'd0, REG_STATUS=2'd1, REG_CTRL=2'd2, REG_RSVD=2'd3).
  - STATUS and CTRL bit-index constants.
  - Write and read FSM state enums.
- Sub-module sync_fifo (DEPTH, DATA_WIDTH):
  - Ports: push, pop, flush, wdata, rdata (head, combinational), full, empty, count.
  - The slave wraps it with the AXI FSMs and decode.

Test Plan:
1. Reset, then write 0xDEEDBEEF, 0xDEEDBEE0, 0xDEEDBEE1, 0xDEEDBEE2 to 0x0 → each BRESP=OKAY. Read 0x4 → RDATA=0x0000_0400. Four reads of 0x0 → the same four values in order, RRESP=OKAY. Final STATUS=0x1.
2. Read 0x0 on an empty FIFO → RDATA=0, RRESP=SLVERR, STATUS stays 0x1.
3. Push 16 words → STATUS=0x0000_1002. 17th push → BRESP=SLVERR, STATUS=0x0000_1006. Write CTRL=0x2 → STATUS=0x0000_1002.
4. Present W two cycles before AW, and separately AW before W → BVALID exactly 1 cycle after the later handshake. Hold BREADY=0 for 3 cycles → BVALID/BRESP stable, AWREADY=0.
5. Push 3 words, write CTRL=0x1 → STATUS=0x1. Next DATA read → SLVERR.
6. With 2 words queued, assert ARESETn low while RVALID=1 and RREADY=0 → RVALID=0 immediately. After release → STATUS=0x1.
